// File: rtl/aes128_package.sv
// Shared AES-128 definitions for the decryption-side key path: byte/word types,
// round constants and the inverse key-schedule state encoding.
package aes128_package;

    typedef logic [7:0]  bv8_t;
    typedef logic [31:0] bv32_t;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic {
        KS_IDLE = 1'b0,
        KS_RUN  = 1'b1
    } ks_state_t;

    // Rcon[r] for r = 1..10; round 0 has no constant and returns zero.
    function automatic bv8_t rcon(input int r);
        bv8_t c;
        case (r)
            1:       c = 8'h01;
            2:       c = 8'h02;
            3:       c = 8'h04;
            4:       c = 8'h08;
            5:       c = 8'h10;
            6:       c = 8'h20;
            7:       c = 8'h40;
            8:       c = 8'h80;
            9:       c = 8'h1b;
            10:      c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/aes128_sbox.sv
// Combinational forward AES S-box, one byte. Shared by the key schedules and cipher rounds.
module aes128_sbox
    import aes128_package::*;
(
    input  bv8_t a,
    output bv8_t s
);

    localparam bv8_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign s = SBOX[a];

endmodule

// File: rtl/aes128_key_schedule_inv.sv
// Iterative AES-128 inverse key expander: loads K10, then streams K10..K0, one
// key per output handshake, from a single 128-bit register and one SubWord stage.
module aes128_key_schedule_inv
    import aes128_package::*;
(
    input  logic         in_clock,
    input  logic         in_reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_key,
    output logic [3:0]   out_round,
    output logic         out_last
);

    ks_state_t    state_q;
    logic [127:0] key_q;
    logic [3:0]   round_q;

    bv32_t w0, w1, w2, w3;
    bv32_t p0, p1, p2, p3;
    bv32_t rot_w, sub_w;
    logic [127:0] prev_key;

    assign {w0, w1, w2, w3} = key_q;

    // Undo the forward chaining: each earlier word is the XOR of two adjacent current words.
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    assign rot_w = {p3[23:0], p3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes128_sbox u_sbox (
            .a (rot_w[8*g +: 8]),
            .s (sub_w[8*g +: 8])
        );
    end

    assign p0       = w0 ^ sub_w ^ {rcon(int'(round_q)), 24'h0};
    assign prev_key = {p0, p1, p2, p3};

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q <= KS_IDLE;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            case (state_q)
                KS_IDLE: begin
                    if (in_valid) begin
                        key_q   <= in_key;
                        round_q <= 4'(NUM_ROUNDS);
                        state_q <= KS_RUN;
                    end
                end
                KS_RUN: begin
                    if (out_ready) begin
                        if (round_q == 4'd0) begin
                            key_q   <= '0;
                            round_q <= '0;
                            state_q <= KS_IDLE;
                        end else begin
                            key_q   <= prev_key;
                            round_q <= round_q - 4'd1;
                        end
                    end
                end
                default: begin
                    key_q   <= '0;
                    round_q <= '0;
                    state_q <= KS_IDLE;
                end
            endcase
        end
    end

    // Every output is a decode of registered state; nothing from in_* reaches out_* in-cycle.
    assign in_ready  = (state_q == KS_IDLE);
    assign out_valid = (state_q == KS_RUN);
    assign out_key   = key_q;
    assign out_round = round_q;
    assign out_last  = (state_q == KS_RUN) && (round_q == 4'd0);

endmodule

// File: tb/tb_aes128_key_schedule_inv.sv
// Bench for the inverse key expander: GF(2^8)-derived S-box, forward and inverse
// word-recurrence models, directed scenarios plus random keys and stalls.
module tb_aes128_key_schedule_inv;

    logic         in_clock   = 1'b0;
    logic         in_reset_n = 1'b0;
    logic         in_valid   = 1'b0;
    logic         in_ready;
    logic [127:0] in_key     = '0;
    logic         out_valid;
    logic         out_ready  = 1'b0;
    logic [127:0] out_key;
    logic [3:0]   out_round;
    logic         out_last;

    aes128_key_schedule_inv dut (
        .in_clock   (in_clock),
        .in_reset_n (in_reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_key     (in_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_key    (out_key),
        .out_round  (out_round),
        .out_last   (out_last)
    );

    always #5 in_clock = ~in_clock;

    int cyc = 0;
    always @(posedge in_clock) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0]   sbm [256];
    logic [7:0]   rcm [11];
    logic [127:0] exp_k [11];
    logic [127:0] got_k [11];
    logic [127:0] fips_k [11];

    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, t, s;
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                repeat (254) inv = gmul(inv, 8'(x));
            end
            t = inv;
            s = inv;
            repeat (4) begin
                t = {t[6:0], t[7]};
                s = s ^ t;
            end
            sbm[x] = s ^ 8'h63;
        end
        rcm[0] = 8'h00;
        rcm[1] = 8'h01;
        for (int i = 2; i <= 10; i++) rcm[i] = xt(rcm[i-1]);
    endtask

    function automatic logic [31:0] gfun(input logic [31:0] w, input int r);
        logic [31:0] rw;
        rw = {w[23:0], w[31:24]};
        return {sbm[rw[31:24]], sbm[rw[23:16]], sbm[rw[15:8]], sbm[rw[7:0]]} ^ {rcm[r], 24'h0};
    endfunction

    task automatic fwd_expand(input logic [127:0] k0);
        logic [31:0] w [44];
        {w[0], w[1], w[2], w[3]} = k0;
        for (int i = 4; i < 44; i++) begin
            logic [31:0] t;
            t = w[i-1];
            if (i % 4 == 0) t = gfun(t, i / 4);
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic inv_expand(input logic [127:0] k10);
        logic [31:0] w [44];
        {w[40], w[41], w[42], w[43]} = k10;
        for (int i = 43; i >= 4; i--) begin
            logic [31:0] t;
            t = w[i-1];
            if (i % 4 == 0) t = gfun(t, i / 4);
            w[i-4] = w[i] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " in_ready"},  128'(in_ready),  128'd1);
        chk({tag, " out_valid"}, 128'(out_valid), 128'd0);
        chk({tag, " out_key"},   out_key,         128'd0);
        chk({tag, " out_round"}, 128'(out_round), 128'd0);
        chk({tag, " out_last"},  128'(out_last),  128'd0);
    endtask

    // Called at a negedge while idle; returns at the negedge holding K10.
    task automatic load(input logic [127:0] k);
        in_key   = k;
        in_valid = 1'b1;
        chk("in_ready idle", 128'(in_ready), 128'd1);
        @(negedge in_clock);
        in_valid = 1'b0;
    endtask

    // Consumes K10..K0 against exp_k, optionally stalling or resetting at abort_at.
    task automatic stream(input int stall_pct, input int abort_at);
        for (int r = 10; r >= 0; r--) begin
            chk("out_valid", 128'(out_valid), 128'd1);
            chk("in_ready busy", 128'(in_ready), 128'd0);
            if (r == abort_at) begin
                in_reset_n = 1'b0;
                #1;
                chk_reset_outs("async reset");
                @(negedge in_clock);
                chk_reset_outs("held reset");
                @(negedge in_clock);
                in_reset_n = 1'b1;
                @(negedge in_clock);
                return;
            end
            for (int s = 0; s < 4 && $urandom_range(99) < stall_pct; s++) begin
                out_ready = 1'b0;
                @(negedge in_clock);
                chk("stall key", out_key, exp_k[r]);
                chk("stall round", 128'(out_round), 128'(r));
            end
            out_ready = 1'b1;
            chk("key", out_key, exp_k[r]);
            chk("round", 128'(out_round), 128'(r));
            chk("last", 128'(out_last), 128'(r == 0));
            got_k[r] = out_key;
            @(negedge in_clock);
        end
        chk("in_ready after K0", 128'(in_ready), 128'd1);
        chk("out_valid after K0", 128'(out_valid), 128'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] other_k10, k0;
        int c0, c1;

        build_tables();
        repeat (2) @(negedge in_clock);
        chk_reset_outs("reset");
        in_reset_n = 1'b1;
        @(negedge in_clock);
        chk_reset_outs("idle");

        // FIPS-197 vector, no stalls
        inv_expand(FIPS_K10);
        load(FIPS_K10);
        stream(0, -1);
        chk("fips K9", got_k[9], 128'hac7766f319fadc2128d12941575c006e);
        chk("fips K1", got_k[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips K0", got_k[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        for (int r = 0; r <= 10; r++) fips_k[r] = got_k[r];

        // Backpressure
        load(FIPS_K10);
        stream(40, -1);
        for (int r = 0; r <= 10; r++) chk("bp sequence", got_k[r], fips_k[r]);

        // Busy rejection: a second key offered for the whole stream
        fwd_expand({$urandom, $urandom, $urandom, $urandom});
        other_k10 = exp_k[10];
        inv_expand(FIPS_K10);
        load(FIPS_K10);
        in_key   = other_k10;
        in_valid = 1'b1;
        stream(20, -1);
        for (int r = 0; r <= 10; r++) chk("busy sequence", got_k[r], fips_k[r]);
        @(negedge in_clock);
        in_valid = 1'b0;
        inv_expand(other_k10);
        stream(0, -1);

        // Reset mid-stream at round 5, then a fresh full load
        inv_expand(FIPS_K10);
        load(FIPS_K10);
        stream(0, 5);
        chk_reset_outs("after reset release");
        load(FIPS_K10);
        stream(0, -1);
        for (int r = 0; r <= 10; r++) chk("post-reset sequence", got_k[r], fips_k[r]);

        // Back-to-back loads with in_valid held high
        in_key   = FIPS_K10;
        in_valid = 1'b1;
        c0 = cyc;
        @(negedge in_clock);
        stream(0, -1);
        c1 = cyc;
        chk("load spacing", 128'(c1 - c0), 128'd12);
        @(negedge in_clock);
        in_valid = 1'b0;
        stream(0, -1);
        for (int r = 0; r <= 10; r++) chk("b2b sequence", got_k[r], fips_k[r]);

        // All-zero K10 against the inverse model
        inv_expand(128'h0);
        load(128'h0);
        stream(25, -1);

        // Random keys from a forward expansion of a random K0
        repeat (3) begin
            k0 = {$urandom, $urandom, $urandom, $urandom};
            fwd_expand(k0);
            load(exp_k[10]);
            stream(30, -1);
            chk("random K0", got_k[0], k0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aes128_key_schedule_inv.md
# aes128_key_schedule_inv

Iterative AES-128 inverse key expander for the decryption datapath. It accepts the final round key K10 once, then streams round keys K10, K9, …, K0 one per output handshake, so the inverse cipher can consume keys in the order it needs them. It replaces a stored 11-entry key table with one 128-bit register and one SubWord stage.

## Interface
- No parameters. Key width fixed at 128 bits, 10 rounds.
- in_clock  input  1  rising-edge clock
- in_reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  K10 offered on in_key
- in_ready  output  1  block idle and accepting a key
- in_key  input  128  round-10 key; word w0 = in_key[127:96], byte a0 = MSB of each word
- out_valid  output  1  out_key holds a valid round key
- out_ready  input  1  consumer accepts out_key
- out_key  output  128  current round key K[out_round]
- out_round  output  4  round index of out_key, 10 down to 0
- out_last  output  1  high with out_valid when out_round == 0

## Operation
- States: IDLE, RUN.
- IDLE: in_ready = 1, out_valid = 0. On in_valid && in_ready: key_q <= in_key, round_q <= 10, go to RUN.
- RUN: in_ready = 0, out_valid = 1, out_key = key_q, out_round = round_q.
  - On out_valid && out_ready with round_q != 0: key_q <= inv_step(key_q, round_q), round_q <= round_q - 1.
  - On out_valid && out_ready with round_q == 0: go to IDLE. key_q and round_q clear to 0.
  - Without out_ready: all outputs hold stable. No data change while a beat is stalled.
- inv_step for round r (current words w0..w3, previous words p0..p3):
  - p3 = w3 ^ w2, p2 = w2 ^ w1, p1 = w1 ^ w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[r], 24'h0}
  - RotWord(a0 a1 a2 a3) = a1 a2 a3 a0
  - Rcon[1..10] = 01 02 04 08 10 20 40 80 1b 36
- in_valid during RUN is ignored because in_ready is low. No queuing of a second key.
- round_q never wraps. Value 0 is terminal, and RUN exits only through the round-0 handshake.

## Timing
- Reset: state = IDLE, key_q = 0, round_q = 0. Outputs: in_ready = 1, out_valid = 0, out_key = 0, out_round = 0, out_last = 0.
- Reset asserted mid-stream aborts immediately and returns to the reset values above. No partial beat is completed.
- Key accepted in cycle t gives out_valid = 1 with K10 in cycle t+1.
- With out_ready held high, one key is delivered per cycle. K0 is delivered in cycle t+11.
- in_ready rises in the cycle after the K0 handshake. Minimum spacing between key loads is 12 cycles.
- The combinational path inside one cycle is one 32-bit SubWord plus the XOR tree. There are no internal pipeline bubbles.
- out_key, out_round and out_last are driven directly from registers. There is no combinational path from in_* to out_*.
- The only combinational input-to-output paths are out_ready → next state and in_valid → next state.

## Structure
- The shared package aes128_package holds these decryption-side definitions:
  - bv8_t and a new 32-bit word typedef bv32_t
  - a round-constant function rcon(int r) returning bv8_t
  - a typedef for the IDLE/RUN state enum
- Sub-module aes128_sbox: combinational byte S-box, bv8_t in, bv8_t out. Four instances form SubWord. The same module is reused by the forward key schedule and the cipher rounds.
- The top level contains the FSM, key_q, round_q and the inv_step XOR network.

## Test plan
- FIPS-197 vector, out_ready held high:
  - in_key = d014f9a8c9ee2589e13f0cc8b6630ca6
  - Expect beats with out_round 10..0.
  - Beat 2 = ac7766f319fadc2128d12941575c006e (K9).
  - Beat 10 = a0fafe1788542cb123a339392a6c7605 (K1).
  - Beat 11 = 2b7e151628aed2a6abf7158809cf4f3c (K0) with out_last = 1.
- Backpressure: same vector with random out_ready stalls.
  - out_key and out_round stay stable through every stall.
  - The key sequence is identical to the no-stall run.
- Busy rejection: pulse in_valid with a different key during RUN.
  - in_ready = 0 throughout.
  - The stream continues unchanged.
  - The new key is accepted only after the K0 handshake, in_ready high one cycle later.
- Reset mid-stream: assert in_reset_n = 0 at out_round = 5.
  - All outputs go to reset values asynchronously.
  - After release, a fresh load of the FIPS key gives the full correct sequence.
- Back-to-back loads: in_valid held high with the same key.
  - Second accept occurs exactly 12 cycles after the first.
  - Second stream matches the first.
- All-zero key: in_key = 0.
  - Every beat matches a software inverse-expansion model, with correct Rcon for rounds 9 (1b) and 10 (36).
